// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with valid/ready word output
// Completed words go to a one-deep held register; an unconsumed word overwritten sets a sticky overrun.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  input  logic             clr,
  input  logic             pready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             xfer;

  always_comb begin
    shifted   = MSB_FIRST ? {q_q[WIDTH-2:0], si} : {si, q_q[WIDTH-1:1]};
    complete  = si_en && (cnt_q == CW'(WIDTH - 1));
    xfer      = pvalid_q && pready;

    q_d       = q_q;
    cnt_d     = cnt_q;
    pdata_d   = pdata_q;
    pvalid_d  = pvalid_q;
    overrun_d = overrun_q;

    if (clr) begin
      q_d       = '0;
      cnt_d     = '0;
      pdata_d   = '0;
      pvalid_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (si_en) begin
        q_d   = shifted;
        cnt_d = complete ? '0 : cnt_q + CW'(1);
      end
      // A new word always wins the output register; losing an unconsumed one is flagged.
      if (complete) begin
        pdata_d  = shifted;
        pvalid_d = 1'b1;
        if (pvalid_q && !pready) overrun_d = 1'b1;
      end else if (xfer) begin
        pvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= '0;
      cnt_q     <= '0;
      pdata_q   <= '0;
      pvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      pdata_q   <= pdata_d;
      pvalid_q  <= pvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign q       = q_q;
  assign pdata   = pdata_q;
  assign pvalid  = pvalid_q;
  assign bit_cnt = cnt_q;
  assign overrun = overrun_q;

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4, word length in bits; SHALL be legal for WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1; 1 means the first serial bit lands in q[WIDTH-1], 0 means it lands in q[0].
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port si, input, 1 bit: serial data in.
REQ-006 Port si_en, input, 1 bit: shift enable; si is accepted only on edges where si_en=1.
REQ-007 Port clr, input, 1 bit: synchronous clear.
REQ-008 Port pready, input, 1 bit: downstream ready for pdata.
REQ-009 Port q, output, WIDTH bits: live shift register contents.
REQ-010 Port pdata, output, WIDTH bits: last completed word, held.
REQ-011 Port pvalid, output, 1 bit: pdata holds an unconsumed word.
REQ-012 Port bit_cnt, output, max(1,$clog2(WIDTH)) bits: bits accepted in the current word, 0..WIDTH-1.
REQ-013 Port overrun, output, 1 bit: sticky flag, a word was overwritten before it was consumed.

Function
REQ-014 Accepted bit with MSB_FIRST=1 SHALL update q to {q[WIDTH-2:0], si}.
REQ-015 Accepted bit with MSB_FIRST=0 SHALL update q to {si, q[WIDTH-1:1]}.
REQ-016 Accepted bit SHALL increment bit_cnt; on bit_cnt=WIDTH-1 it SHALL wrap to 0 and mark the word complete.
REQ-017 On word complete, pdata SHALL load the post-shift q value, including the current si, on the same edge; pvalid SHALL be 1 after that edge (zero added latency).
REQ-018 With si_en=0, q and bit_cnt SHALL hold; only the handshake logic may change state.
REQ-019 Transfer SHALL occur on an edge where pvalid=1 and pready=1; pvalid SHALL go to 0 after it unless REQ-020 applies.
REQ-020 Transfer and word complete on the same edge: pdata SHALL load the new word, pvalid SHALL stay 1, overrun unchanged.
REQ-021 Word complete with pvalid=1 and pready=0: pdata SHALL be overwritten with the new word, pvalid SHALL stay 1, overrun SHALL be set to 1.
REQ-022 pready while pvalid=0 SHALL have no effect.
REQ-023 overrun SHALL remain 1 until rst or clr.
REQ-024 clr=1 SHALL zero q, bit_cnt, pdata, pvalid and overrun on the next edge, and SHALL take priority over si_en and pready on that edge.
REQ-025 pdata SHALL be stable whenever pvalid=1, except on edges covered by REQ-020 and REQ-021.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force q=0, pdata=0, pvalid=0, bit_cnt=0 and overrun=0.
REQ-027 While rst=1, all state SHALL hold at reset values regardless of clk, si_en, clr and pready.
REQ-028 rst asserted mid-word SHALL discard the partial word; after release, the next accepted bit SHALL be bit 0 of a new word.

Verification (WIDTH=4 unless stated)
REQ-029 MSB_FIRST=1, si_en=1, si=1,1,0,0 on four edges, pready=0 -> after 4th edge pdata=4'b1100, pvalid=1, bit_cnt=0, overrun=0.
REQ-030 MSB_FIRST=0, same stream -> pdata=4'b0011, pvalid=1.
REQ-031 Two words 1,1,0,0 then 1,0,1,0 (MSB_FIRST=1), pready=0 -> pdata=4'b1010, pvalid=1, overrun=1; then clr -> all outputs 0.
REQ-032 pready=1 on the edge completing the second word -> pdata=4'b1010, pvalid=1, overrun=0; pready=1 one more edge -> pvalid=0.
REQ-033 si_en toggled 1,0,1,0,1,0,1 with si=1 on enabled edges -> pdata=4'b1111 only after the 4th enabled edge; bit_cnt holds on disabled edges.
REQ-034 rst pulsed between clock edges after 2 bits -> outputs 0 immediately; next 4 bits 0,1,1,0 -> pdata=4'b0110.
